// File: rtl/pred_update_ctrl.sv
// Branch-prediction update controller.
// Reads a 2-bit saturating counter from an external 128x2 table at lookup time
// and hands out the prediction. It keeps the line and counter of every
// outstanding branch in an in-order queue. On resolve it writes the adjusted
// counter back to the table in a one-cycle UPDATE slot. Because the table writes
// on every edge, the block feeds the read data straight back whenever no update
// is pending.
module pred_update_ctrl #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     lookup_valid,
  input  logic [31:0]              lookup_pc,
  output logic                     lookup_ready,
  output logic                     pred_taken,
  input  logic                     resolve_valid,
  input  logic                     resolve_taken,
  output logic                     mispredict,
  output logic [6:0]               tbl_line,
  output logic [1:0]               tbl_din,
  input  logic [1:0]               tbl_dout,
  output logic [$clog2(DEPTH):0]   q_count,
  output logic                     err_underflow
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0]   FULL_CNT = (PW+1)'(DEPTH);
  localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
  localparam logic [PW:0]   CNT_ZERO = '0;
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  typedef enum logic {IDLE = 1'b0, UPDATE = 1'b1} state_t;

  state_t          st, st_nxt;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [PW:0]     count;
  logic [6:0]      fifo_line [DEPTH];
  logic [1:0]      fifo_cnt  [DEPTH];
  logic [6:0]      upd_line_p1;
  logic [1:0]      upd_cnt_p1;
  logic            push, pop;
  logic [6:0]      head_line;
  logic [1:0]      head_cnt;
  logic            unused_pc_bits;

  // Saturating two-bit counter step toward the observed outcome.
  function automatic logic [1:0] sat_step(input logic [1:0] cnt, input logic taken);
    if (taken) sat_step = (cnt == 2'd3) ? 2'd3 : cnt + 2'd1;
    else       sat_step = (cnt == 2'd0) ? 2'd0 : cnt - 2'd1;
  endfunction

  assign unused_pc_bits = ^{lookup_pc[31:9], lookup_pc[1:0]};

  assign head_line = fifo_line[rd_ptr];
  assign head_cnt  = fifo_cnt[rd_ptr];
  assign push      = lookup_valid && lookup_ready;
  assign pop       = resolve_valid && (count != CNT_ZERO);
  assign q_count   = count;

  // State register: UPDATE only ever follows a cycle that popped a resolve.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) st <= IDLE;
    else       st <= st_nxt;
  end

  // Next state: every successful pop schedules exactly one write-back slot.
  always_comb begin
    st_nxt = IDLE;
    if (pop) st_nxt = UPDATE;
  end

  // Table port and lookup handshake; during UPDATE the table port is owned by the write-back.
  always_comb begin
    tbl_line     = lookup_pc[8:2];
    tbl_din      = tbl_dout;
    pred_taken   = tbl_dout[1];
    lookup_ready = !reset && (count < FULL_CNT);
    if (st == UPDATE) begin
      tbl_line     = upd_line_p1;
      tbl_din      = upd_cnt_p1;
      pred_taken   = 1'b0;
      lookup_ready = 1'b0;
    end
  end

  // Queue pointers and occupancy; simultaneous push and pop cancel out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Queue storage: line and counter as read at lookup time.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_line[wr_ptr] <= lookup_pc[8:2];
      fifo_cnt[wr_ptr]  <= tbl_dout;
    end
  end

  // ---- stage p1: pending write-back computed from the captured counter ----
  always_ff @(posedge clk) begin
    if (pop) begin
      upd_line_p1 <= head_line;
      upd_cnt_p1  <= sat_step(head_cnt, resolve_taken);
    end
  end

  // Mispredict pulse and sticky underflow flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mispredict    <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      mispredict <= pop && (resolve_taken != head_cnt[1]);
      if (resolve_valid && (count == CNT_ZERO)) err_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pred_update_ctrl.sv
// Directed bench for pred_update_ctrl with a behavioural 128x2 predictor table.
module tb_pred_update_ctrl;

  logic        clk;
  logic        reset;
  logic        lookup_valid;
  logic [31:0] lookup_pc;
  logic        lookup_ready;
  logic        pred_taken;
  logic        resolve_valid;
  logic        resolve_taken;
  logic        mispredict;
  logic [6:0]  tbl_line;
  logic [1:0]  tbl_din;
  logic [1:0]  tbl_dout;
  logic [2:0]  q_count;
  logic        err_underflow;

  logic [1:0]  tbl [128];

  int n_chk;
  int n_fail;

  pred_update_ctrl #(.DEPTH(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .lookup_valid (lookup_valid),
    .lookup_pc    (lookup_pc),
    .lookup_ready (lookup_ready),
    .pred_taken   (pred_taken),
    .resolve_valid(resolve_valid),
    .resolve_taken(resolve_taken),
    .mispredict   (mispredict),
    .tbl_line     (tbl_line),
    .tbl_din      (tbl_din),
    .tbl_dout     (tbl_dout),
    .q_count      (q_count),
    .err_underflow(err_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Predictor table: combinational read, write on every rising edge.
  assign tbl_dout = tbl[tbl_line];
  always @(posedge clk) tbl[tbl_line] <= tbl_din;

  typedef struct {
    logic        lv;
    logic [31:0] pc;
    logic        rv;
    logic        rt;
    logic        e_ready;
    logic        e_pred;
    logic        e_misp;
    logic [2:0]  e_q;
    logic [6:0]  e_line;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic lv, input logic [31:0] pc, input logic rv, input logic rt);
    lookup_valid  = lv;
    lookup_pc     = pc;
    resolve_valid = rv;
    resolve_taken = rt;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    for (int i = 0; i < 128; i++) tbl[i] = 2'd1;
    tbl[0] = 2'd3;
    tbl[3] = 2'd0;
    tbl[5] = 2'd1;

    //          lv    pc        rv    rt    rdy   pred  misp  q     line
    vecs[0] = '{1'b1, 32'h14, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 7'd5};
    vecs[1] = '{1'b0, 32'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'd1, 7'd0};
    vecs[2] = '{1'b0, 32'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 7'd5};
    vecs[3] = '{1'b1, 32'h14, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 7'd5};
    vecs[4] = '{1'b1, 32'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'd1, 7'd0};
    vecs[5] = '{1'b1, 32'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 7'd5};
    vecs[6] = '{1'b0, 32'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 7'd0};
    vecs[7] = '{1'b1, 32'h0C, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 7'd3};
    vecs[8] = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd1, 7'd0};
    vecs[9] = '{1'b0, 32'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 7'd3};

    reset = 1'b1;
    drive(1'b1, 32'h28, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", lookup_ready, 0);
    chk("rst_q", q_count, 0);
    chk("rst_misp", mispredict, 0);
    chk("rst_err", err_underflow, 0);
    chk("rst_line", tbl_line, 10);
    chk("rst_din", tbl_din, 1);

    // Table-driven sequence: update, saturation, chained resolve, no bypass.
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].lv, vecs[i].pc, vecs[i].rv, vecs[i].rt);
      #1;
      chk($sformatf("v%0d_ready", i), lookup_ready, vecs[i].e_ready);
      chk($sformatf("v%0d_pred", i), pred_taken, vecs[i].e_pred);
      chk($sformatf("v%0d_misp", i), mispredict, vecs[i].e_misp);
      chk($sformatf("v%0d_q", i), q_count, vecs[i].e_q);
      chk($sformatf("v%0d_line", i), tbl_line, vecs[i].e_line);
      step();
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    chk("tbl5_after", tbl[5], 3);
    chk("tbl0_sat", tbl[0], 3);
    chk("tbl3_sat", tbl[3], 0);

    // Fill the queue, then resolve in the full cycle and keep resolving back-to-back.
    drive(1'b1, 32'h04, 1'b0, 1'b0); #1; chk("fill0_ready", lookup_ready, 1); step();
    drive(1'b1, 32'h08, 1'b0, 1'b0); #1; chk("fill1_q", q_count, 1); step();
    drive(1'b1, 32'h10, 1'b0, 1'b0); #1; chk("fill2_q", q_count, 2); step();
    drive(1'b1, 32'h18, 1'b0, 1'b0); #1; chk("fill3_ready", lookup_ready, 1); step();
    drive(1'b1, 32'h1C, 1'b1, 1'b1); #1;
    chk("full_q", q_count, 4);
    chk("full_ready", lookup_ready, 0);
    step();
    #1;
    chk("pop_full_q", q_count, 3);
    chk("chain0_ready", lookup_ready, 0);
    chk("chain0_line", tbl_line, 1);
    chk("chain0_din", tbl_din, 2);
    chk("chain0_misp", mispredict, 1);
    step();
    #1;
    chk("chain1_ready", lookup_ready, 0);
    chk("chain1_line", tbl_line, 2);
    chk("chain1_q", q_count, 2);
    step();
    #1;
    chk("chain2_ready", lookup_ready, 0);
    chk("chain2_line", tbl_line, 4);
    chk("chain2_q", q_count, 1);
    step();
    drive(1'b1, 32'h1C, 1'b0, 1'b0); #1;
    chk("chain3_ready", lookup_ready, 0);
    chk("chain3_line", tbl_line, 6);
    chk("chain3_q", q_count, 0);
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b0); #1;
    chk("drain_ready", lookup_ready, 1);
    chk("drain_q", q_count, 0);
    chk("tbl1", tbl[1], 2);
    chk("tbl2", tbl[2], 2);
    chk("tbl4", tbl[4], 2);
    chk("tbl6", tbl[6], 2);
    chk("tbl7_untouched", tbl[7], 1);

    // Resolve with an empty queue.
    drive(1'b0, 32'h0, 1'b1, 1'b1); #1;
    chk("uf_err_before", err_underflow, 0);
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b0); #1;
    chk("uf_err", err_underflow, 1);
    chk("uf_q", q_count, 0);
    chk("uf_misp", mispredict, 0);
    chk("uf_ready", lookup_ready, 1);
    chk("uf_tbl0", tbl[0], 3);
    step();
    step();
    #1;
    chk("uf_sticky", err_underflow, 1);

    // Reset in the UPDATE cycle discards the pending write.
    drive(1'b1, 32'h1C, 1'b0, 1'b0); #1;
    chk("c_push_ready", lookup_ready, 1);
    step();
    drive(1'b0, 32'h0, 1'b1, 1'b1);
    step();
    drive(1'b0, 32'h1C, 1'b0, 1'b0); #1;
    chk("c_upd_misp", mispredict, 1);
    chk("c_upd_line", tbl_line, 7);
    chk("c_upd_din", tbl_din, 2);
    reset = 1'b1;
    #1;
    chk("c_rst_ready", lookup_ready, 0);
    chk("c_rst_misp", mispredict, 0);
    chk("c_rst_q", q_count, 0);
    chk("c_rst_err", err_underflow, 0);
    chk("c_rst_line", tbl_line, 7);
    chk("c_rst_din", tbl_din, 1);
    step();
    #1;
    chk("c_tbl7_kept", tbl[7], 1);
    @(negedge clk);
    reset = 1'b0;
    drive(1'b1, 32'h1C, 1'b0, 1'b0); #1;
    chk("first_ready", lookup_ready, 1);
    chk("first_pred", pred_taken, 0);
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b0); #1;
    chk("first_q", q_count, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pred_update_ctrl.md
PRED_UPDATE_CTRL -- requirements
Module: pred_update_ctrl

Interface
REQ-001 Parameter: DEPTH, 4, maximum number of in-flight predictions (power of 2, 2..8).
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 reset  input  1  reset, asynchronous, active-high.
REQ-004 lookup_valid  input  1  fetch requests a prediction this cycle.
REQ-005 lookup_pc  input  32  fetch PC of the branch.
REQ-006 lookup_ready  output  1  lookup accepted this cycle when high with lookup_valid.
REQ-007 pred_taken  output  1  prediction for the accepted lookup, combinational, same cycle.
REQ-008 resolve_valid  input  1  execute resolves the oldest outstanding branch.
REQ-009 resolve_taken  input  1  actual outcome of that branch.
REQ-010 mispredict  output  1  registered; pulses one cycle after a resolve whose outcome differs from the stored prediction.
REQ-011 tbl_line  output  7  index to the 128x2 predictor table.
REQ-012 tbl_din  output  2  write data to the table; the table writes it every clock edge.
REQ-013 tbl_dout  input  2  combinational read data from the table at tbl_line.
REQ-014 q_count  output  $clog2(DEPTH)+1  number of outstanding predictions.
REQ-015 err_underflow  output  1  sticky; resolve received with an empty queue.

Function
REQ-016 Counter encoding: 0 strong-not-taken, 1 weak-not-taken, 2 weak-taken, 3 strong-taken; predicted taken = counter bit 1.
REQ-017 Table index of a lookup = lookup_pc[8:2].
REQ-018 The table writes on every edge, so the block drives tbl_din = tbl_dout in every cycle with no pending update, keeping table contents unchanged.
REQ-019 State: IDLE (no update pending) and UPDATE (one update pending); UPDATE lasts exactly one cycle.
REQ-020 IDLE: tbl_line = lookup_pc[8:2], tbl_din = tbl_dout, pred_taken = tbl_dout[1].
REQ-021 UPDATE: tbl_line = stored update line, tbl_din = stored new counter, lookup_ready = 0, pred_taken = 0.
REQ-022 lookup_ready = 1 only in IDLE with q_count < DEPTH; uses the count at the start of the cycle, so no push when full, even if a pop occurs in the same cycle.
REQ-023 Accepted lookup pushes {line, tbl_dout} into an in-order FIFO of DEPTH entries; pointers wrap modulo DEPTH.
REQ-024 resolve_valid with a non-empty queue pops the head. It computes the new counter from the stored counter: taken -> min(cnt+1,3), not taken -> max(cnt-1,0). It registers {line, new cnt} and enters UPDATE next cycle.
REQ-025 Update uses the counter captured at lookup time, not the current table value.
REQ-026 mispredict = (resolve_taken != stored cnt[1]), registered in the same edge that enters UPDATE; low otherwise.
REQ-027 resolve_valid is legal in UPDATE. Resolves arriving on consecutive cycles chain: UPDATE is re-entered directly, and lookups stall until a resolve-free cycle.
REQ-028 Push and pop in the same cycle leave q_count unchanged.
REQ-029 A lookup in the same cycle as a resolve to the same line reads the pre-update value; no bypass.
REQ-030 resolve_valid with q_count = 0: ignored (no pop, no UPDATE, no mispredict); err_underflow set to 1 until reset.
REQ-031 Inputs lookup_pc and resolve_taken are don't-care when their valid is low.

Reset
REQ-032 While reset is high: FIFO empty, q_count = 0, state IDLE, mispredict = 0, err_underflow = 0, lookup_ready = 0.
REQ-033 While reset is high: tbl_line = lookup_pc[8:2] and tbl_din = tbl_dout, so table contents are preserved.
REQ-034 Reset asserted mid-UPDATE discards the pending update; the table line keeps its old value.
REQ-035 First lookup accepted in the first cycle after reset deasserts.

Verification
REQ-036 Table line 5 = 1, lookup pc=0x14, then resolve taken -> pred_taken=0, mispredict=1 next cycle, line 5 = 2 after UPDATE.
REQ-037 Line 0 = 3, lookup pc=0x0, resolve taken -> mispredict=0, line 0 stays 3 (saturation). Line 3 = 0 with resolve not-taken -> stays 0.
REQ-038 Four lookups with DEPTH=4, no resolve -> q_count=4, lookup_ready=0 on the fifth. A simultaneous resolve in the full cycle -> no push, q_count=3 next cycle.
REQ-039 Resolves on three consecutive cycles -> three UPDATE cycles back-to-back, lookup_ready=0 throughout, table lines updated in FIFO order.
REQ-040 Resolve with empty queue -> err_underflow=1 and stays 1, q_count=0, no table change; reset clears it.
REQ-041 Reset asserted in the UPDATE cycle -> target line unchanged, q_count=0, mispredict=0.
